// File: rtl/ahb_txn_monitor.sv
// ahb_txn_monitor
//   Passive AHB-Lite monitor for one slave. Pairs each accepted address phase
//   with its completing data phase and pushes a transaction record into a small
//   FIFO. A scoreboard drains the FIFO over a valid/ready port. The monitor also
//   keeps overflow, drop, transaction and response-protocol statistics. It only
//   observes the bus and never drives it.
//
// Ports
//   HCLK, HRESETn           bus clock, asynchronous active-low reset
//   HSEL..HRESP             sampled AHB-Lite slave-side signals
//   rec_valid/rec_ready     record FIFO head handshake
//   rec_addr..rec_prot      fields of the FIFO head record (zero when empty)
//   clr_stat                synchronous clear of ovf, drop_cnt, txn_cnt, proto_err
//   level                   FIFO occupancy 0..DEPTH
//   ovf, drop_cnt           sticky drop flag, saturating drop count
//   txn_cnt                 wrapping count of completed transfers
//   proto_err               sticky ERROR-response protocol violation
module ahb_txn_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH-1:0]   HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [ADDR_WIDTH-1:0]   rec_addr,
  output logic [DATA_WIDTH-1:0]   rec_data,
  output logic                    rec_write,
  output logic                    rec_seq,
  output logic                    rec_err,
  output logic [2:0]              rec_size,
  output logic [2:0]              rec_burst,
  output logic [3:0]              rec_prot,
  input  logic                    clr_stat,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic [15:0]             drop_cnt,
  output logic [31:0]             txn_cnt,
  output logic                    proto_err
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR2} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic                  seq;
    logic                  err;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
  } rec_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic                  p_write;
  logic                  p_seq;
  logic [2:0]            p_size;
  logic [2:0]            p_burst;
  logic [3:0]            p_prot;

  logic accept;
  logic complete;
  logic comp_err;
  logic comp_proto;
  rec_t comp_rec;

  assign accept = HREADY & HSEL & HTRANS[1];

  // Completion decode. An ERR2 cycle always completes the pending transfer:
  // either the legal second ERROR cycle, or a malformed one that is flagged.
  always_comb begin
    complete   = 1'b0;
    comp_err   = 1'b0;
    comp_proto = 1'b0;
    case (state)
      S_DATA: begin
        if (HREADY) begin
          complete   = 1'b1;
          comp_err   = HRESP;
          comp_proto = HRESP;   // ERROR without the preceding wait cycle
        end
      end
      S_ERR2: begin
        complete   = 1'b1;
        comp_err   = 1'b1;
        comp_proto = !(HREADY && HRESP);
      end
      default: ;
    endcase
  end

  assign comp_rec = '{addr:  p_addr,
                      data:  p_write ? HWDATA : HRDATA,
                      write: p_write,
                      seq:   p_seq,
                      err:   comp_err,
                      size:  p_size,
                      burst: p_burst,
                      prot:  p_prot};

  // Transfer-tracking FSM and pending address slot. A new address can only be
  // accepted on an HREADY=1 edge, which is also an edge that completes any
  // outstanding transfer, so acceptance always leads to DATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      p_addr  <= '0;
      p_write <= 1'b0;
      p_seq   <= 1'b0;
      p_size  <= 3'd0;
      p_burst <= 3'd0;
      p_prot  <= 4'd0;
    end else begin
      if (accept) begin
        state   <= S_DATA;
        p_addr  <= HADDR;
        p_write <= HWRITE;
        p_seq   <= HTRANS[0];
        p_size  <= HSIZE;
        p_burst <= HBURST;
        p_prot  <= HPROT;
      end else if (complete) begin
        state <= S_IDLE;
      end else if (state == S_DATA && !HREADY && HRESP) begin
        state <= S_ERR2;
      end
    end
  end

  // Record FIFO
  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop;
  rec_t          head;

  assign full    = (count == LW'(DEPTH));
  assign pop     = rec_valid & rec_ready;
  assign do_push = complete & (!full | pop);  // a pop frees the slot on the same edge
  assign drop    = complete & full & !pop;

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= comp_rec;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head fields read as zero whenever the FIFO is empty, so the record port is
  // all-zero out of reset without clearing the storage array.
  assign rec_valid = (count != '0);
  assign head      = rec_valid ? mem[rd_ptr] : '0;
  assign rec_addr  = head.addr;
  assign rec_data  = head.data;
  assign rec_write = head.write;
  assign rec_seq   = head.seq;
  assign rec_err   = head.err;
  assign rec_size  = head.size;
  assign rec_burst = head.burst;
  assign rec_prot  = head.prot;
  assign level     = count;

  // Statistics; clr_stat takes priority over any same-edge update.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ovf       <= 1'b0;
      drop_cnt  <= 16'd0;
      txn_cnt   <= 32'd0;
      proto_err <= 1'b0;
    end else if (clr_stat) begin
      ovf       <= 1'b0;
      drop_cnt  <= 16'd0;
      txn_cnt   <= 32'd0;
      proto_err <= 1'b0;
    end else begin
      if (complete) txn_cnt <= txn_cnt + 32'd1;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (comp_proto) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_txn_monitor.sv
// tb_ahb_txn_monitor
//   Directed bench for ahb_txn_monitor. Stimulus tasks drive bus cycles and
//   announce the record each completing edge must produce. A queue-based model
//   tracks FIFO contents and statistics, and a negedge process compares the DUT
//   against it every cycle. Literal checks pin key values of the scenarios.
module tb_ahb_txn_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
    logic        seq;
    logic        err;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
  } rec_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd0;
  logic [2:0]    HBURST = 3'd0;
  logic [3:0]    HPROT = 4'd0;
  logic [DW-1:0] HWDATA = '0;
  logic [DW-1:0] HRDATA = '0;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic          rec_valid;
  logic          rec_ready = 1'b1;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_data;
  logic          rec_write, rec_seq, rec_err;
  logic [2:0]    rec_size, rec_burst;
  logic [3:0]    rec_prot;
  logic          clr_stat = 1'b0;
  logic [3:0]    level;
  logic          ovf;
  logic [15:0]   drop_cnt;
  logic [31:0]   txn_cnt;
  logic          proto_err;

  ahb_txn_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_write(rec_write), .rec_seq(rec_seq),
    .rec_err(rec_err), .rec_size(rec_size), .rec_burst(rec_burst),
    .rec_prot(rec_prot), .clr_stat(clr_stat), .level(level), .ovf(ovf),
    .drop_cnt(drop_cnt), .txn_cnt(txn_cnt), .proto_err(proto_err)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic s, input logic e, input logic [2:0] sz,
                              input logic [2:0] bu, input logic [3:0] pr);
    rec_t r;
    r = '{addr: a, data: d, write: w, seq: s, err: e, size: sz, burst: bu, prot: pr};
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  bit   exp_push  = 1'b0;
  bit   exp_proto = 1'b0;
  rec_t exp_rec   = '0;
  rec_t mq[$];
  int   m_txn = 0;
  int   m_drop = 0;
  bit   m_ovf = 1'b0;
  bit   m_proto = 1'b0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mq.delete();
      m_txn = 0; m_drop = 0; m_ovf = 1'b0; m_proto = 1'b0;
    end else begin
      if (mq.size() > 0 && rec_ready) void'(mq.pop_front());
      if (exp_push) begin
        m_txn = m_txn + 1;
        if (mq.size() < D) mq.push_back(exp_rec);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop = m_drop + 1;
        end
        $display("txn addr=%08h data=%08h w=%0d seq=%0d err=%0d", exp_rec.addr,
                 exp_rec.data, exp_rec.write, exp_rec.seq, exp_rec.err);
      end
      if (exp_proto) m_proto = 1'b1;
      if (clr_stat) begin
        m_txn = 0; m_drop = 0; m_ovf = 1'b0; m_proto = 1'b0;
      end
    end
  end

  always @(negedge HCLK) begin
    chk("m_valid", rec_valid, mq.size() != 0);
    chk("m_level", level, mq.size());
    chk("m_ovf", ovf, m_ovf);
    chk("m_drop", drop_cnt, m_drop);
    chk("m_txn", txn_cnt, m_txn);
    chk("m_proto", proto_err, m_proto);
    if (mq.size() != 0) begin
      chk("m_addr", rec_addr, mq[0].addr);
      chk("m_data", rec_data, mq[0].data);
      chk("m_flags", {rec_write, rec_seq, rec_err, rec_size, rec_burst, rec_prot},
          {mq[0].write, mq[0].seq, mq[0].err, mq[0].size, mq[0].burst, mq[0].prot});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_addr(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                          input logic w, input logic [2:0] sz, input logic [2:0] bu,
                          input logic [3:0] pr);
    HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = w; HSIZE = sz; HBURST = bu; HPROT = pr;
  endtask

  task automatic set_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0;
  endtask

  task automatic set_resp(input logic rdy, input logic resp, input logic [31:0] wd,
                          input logic [31:0] rd);
    HREADY = rdy; HRESP = resp; HWDATA = wd; HRDATA = rd;
  endtask

  task automatic expect_rec(input rec_t r, input bit proto);
    exp_push = 1'b1; exp_rec = r; exp_proto = proto;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
    exp_push = 1'b0; exp_proto = 1'b0; clr_stat = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1 HRESETn = 1'b0;
    #2;
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_stats", {ovf, drop_cnt, txn_cnt, proto_err}, '0);
    chk("rst_fields", {rec_addr, rec_data}, '0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    set_idle(); set_resp(1, 0, 0, 0);
    tick();

    // Single write, zero waits; consumer stalls so the record is held.
    rec_ready = 1'b0;
    set_addr(1, 2'b10, 32'h100, 1, 3'd2, 3'd0, 4'h3);
    tick();
    chk("w1_valid_accept", rec_valid, 1'b0);
    set_idle(); set_resp(1, 0, 32'hDEADBEEF, 32'h0);
    expect_rec(mk(32'h100, 32'hDEADBEEF, 1, 0, 0, 3'd2, 3'd0, 4'h3), 0);
    tick();
    chk("w1_valid", rec_valid, 1'b1);
    chk("w1_addr", rec_addr, 32'h100);
    chk("w1_data", rec_data, 32'hDEADBEEF);
    chk("w1_wse", {rec_write, rec_seq, rec_err}, 3'b100);
    chk("w1_txn", txn_cnt, 32'd1);
    tick();
    rec_ready = 1'b1;
    tick();
    chk("w1_drained", level, 4'd0);

    // INCR4 read burst at 0x200, zero waits.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_addr(1, (i == 0) ? 2'b10 : 2'b11, 32'h200 + 4 * i, 0, 3'd2, 3'd3, 4'h1);
      else       set_idle();
      set_resp(1, 0, 32'h0, 32'hA000_0000 + i - 1);
      if (i > 0) expect_rec(mk(32'h200 + 4 * (i - 1), 32'hA000_0000 + i - 1, 0,
                               (i > 1), 0, 3'd2, 3'd3, 4'h1), 0);
      tick();
      if (i == 2) chk("b4_seq", rec_seq, 1'b1);
    end
    chk("b4_txn", txn_cnt, 32'd5);
    tick();

    // Write with three wait states; HWDATA moves during the waits.
    set_addr(1, 2'b10, 32'h40, 1, 3'd2, 3'd0, 4'h2); set_resp(1, 0, 0, 0);
    tick();
    set_idle();
    set_resp(0, 0, 32'h11111111, 0); tick();
    set_resp(0, 0, 32'h22222222, 0); tick();
    set_resp(0, 0, 32'h33333333, 0); tick();
    chk("ws_level_wait", level, 4'd0);
    set_resp(1, 0, 32'h44444444, 0);
    expect_rec(mk(32'h40, 32'h44444444, 1, 0, 0, 3'd2, 3'd0, 4'h2), 0);
    tick();
    chk("ws_level_peak", level, 4'd1);
    chk("ws_data", rec_data, 32'h44444444);
    tick();

    // Two-cycle ERROR response: legal.
    set_addr(1, 2'b10, 32'h300, 0, 3'd2, 3'd0, 4'h0); set_resp(1, 0, 0, 0);
    tick();
    set_idle(); set_resp(0, 1, 0, 32'hBAD0); tick();
    set_resp(1, 1, 0, 32'hBAD1);
    expect_rec(mk(32'h300, 32'hBAD1, 0, 0, 1, 3'd2, 3'd0, 4'h0), 0);
    tick();
    chk("e2_err", rec_err, 1'b1);
    chk("e2_proto", proto_err, 1'b0);
    set_resp(1, 0, 0, 0); tick();

    // Malformed second ERROR cycle: completes with err and flags protocol.
    set_addr(1, 2'b10, 32'h308, 0, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); set_resp(0, 1, 0, 0); tick();
    set_resp(0, 0, 0, 32'hBAD2);
    expect_rec(mk(32'h308, 32'hBAD2, 0, 0, 1, 3'd2, 3'd0, 4'h0), 1);
    tick();
    set_resp(1, 0, 0, 0); tick();

    // Single-cycle ERROR.
    set_addr(1, 2'b10, 32'h304, 1, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); set_resp(1, 1, 32'h5555, 0);
    expect_rec(mk(32'h304, 32'h5555, 1, 0, 1, 3'd2, 3'd0, 4'h0), 1);
    tick();
    chk("e1_err", rec_err, 1'b1);
    chk("e1_proto", proto_err, 1'b1);
    set_resp(1, 0, 0, 0);

    // BUSY and deselected transfers produce nothing.
    set_addr(1, 2'b01, 32'h600, 0, 3'd2, 3'd0, 4'h0); tick();
    set_addr(0, 2'b10, 32'h604, 0, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); tick();
    chk("ign_level", level, 4'd0);
    clr_stat = 1'b1; tick();
    chk("clr_txn", txn_cnt, 32'd0);
    chk("clr_proto", proto_err, 1'b0);

    // Overflow: 11 transfers into an 8-entry FIFO with the consumer stalled.
    rec_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 11) set_addr(1, 2'b10, 32'h1000 + 4 * i, 1, 3'd2, 3'd1, 4'h1);
      else        set_idle();
      set_resp(1, 0, (i > 0) ? 32'hC000_0000 + i - 1 : 32'h0, 0);
      if (i > 0) expect_rec(mk(32'h1000 + 4 * (i - 1), 32'hC000_0000 + i - 1, 1, 0, 0,
                               3'd2, 3'd1, 4'h1), 0);
      tick();
    end
    chk("ov_level", level, 4'd8);
    chk("ov_ovf", ovf, 1'b1);
    chk("ov_drop", drop_cnt, 16'd3);
    chk("ov_txn", txn_cnt, 32'd11);
    chk("ov_head", rec_addr, 32'h1000);
    clr_stat = 1'b1; tick();
    chk("ovc_ovf", ovf, 1'b0);
    chk("ovc_drop", drop_cnt, 16'd0);
    chk("ovc_level", level, 4'd8);

    // Drop and clr_stat on the same edge: clear wins.
    set_addr(1, 2'b10, 32'h2000, 1, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); set_resp(1, 0, 32'h5A5A, 0);
    expect_rec(mk(32'h2000, 32'h5A5A, 1, 0, 0, 3'd2, 3'd0, 4'h0), 0);
    clr_stat = 1'b1;
    tick();
    chk("dc_ovf", ovf, 1'b0);
    chk("dc_drop", drop_cnt, 16'd0);
    chk("dc_txn", txn_cnt, 32'd0);

    // Push and pop on the same edge while full.
    set_addr(1, 2'b10, 32'h3000, 1, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); set_resp(1, 0, 32'h77, 0);
    expect_rec(mk(32'h3000, 32'h77, 1, 0, 0, 3'd2, 3'd0, 4'h0), 0);
    rec_ready = 1'b1;
    tick();
    chk("pp_level", level, 4'd8);
    chk("pp_drop", drop_cnt, 16'd0);
    chk("pp_head", rec_addr, 32'h1004);
    repeat (8) tick();
    chk("pp_drained", level, 4'd0);

    // Reset in the DATA state with three records queued.
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_addr(1, 2'b10, 32'h400 + 4 * i, 1, 3'd2, 3'd0, 4'h0);
      set_resp(1, 0, (i > 0) ? 32'hE000_0000 + i - 1 : 32'h0, 0);
      if (i > 0) expect_rec(mk(32'h400 + 4 * (i - 1), 32'hE000_0000 + i - 1, 1, 0, 0,
                               3'd2, 3'd0, 4'h0), 0);
      tick();
    end
    set_idle(); set_resp(0, 0, 0, 0); tick();
    chk("rs_level_pre", level, 4'd3);
    HRESETn = 1'b0;
    #1;
    chk("rs_valid", rec_valid, 1'b0);
    chk("rs_level", level, 4'd0);
    chk("rs_stats", {ovf, drop_cnt, txn_cnt, proto_err}, '0);
    chk("rs_fields", {rec_addr, rec_data}, '0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    set_resp(1, 0, 0, 0); rec_ready = 1'b1;
    tick();
    set_addr(1, 2'b10, 32'h500, 1, 3'd2, 3'd0, 4'h0); tick();
    set_idle(); set_resp(1, 0, 32'h1234, 0);
    expect_rec(mk(32'h500, 32'h1234, 1, 0, 0, 3'd2, 3'd0, 4'h0), 0);
    tick();
    chk("rs_txn", txn_cnt, 32'd1);
    chk("rs_addr", rec_addr, 32'h500);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_txn_monitor.md
# ahb_txn_monitor

Passive, parametrised AHB-Lite transaction monitor for the verification environment. It samples one slave's address and data phases, pairs each accepted address phase with its completing data phase, and packs the result into a transaction record. Records are buffered in an internal FIFO and drained over a valid/ready port by the scoreboard or coverage collector. It also maintains drop/overflow statistics and a response-protocol check. It never drives the bus.

## Interface

Parameters:
- ADDR_WIDTH, 32, HADDR/record address width (≥ 8)
- DATA_WIDTH, 32, HWDATA/HRDATA/record data width (32 or 64)
- DEPTH, 8, record FIFO entries; power of two, ≥ 2
- LW, $clog2(DEPTH)+1, width of `level` (derived, not overridable)

Ports:
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select
- HADDR  in  ADDR_WIDTH  address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  direction
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type
- HPROT  in  4  protection
- HWDATA  in  DATA_WIDTH  write data
- HRDATA  in  DATA_WIDTH  read data
- HREADY  in  1  bus ready (muxed HREADYOUT)
- HRESP  in  1  0=OKAY, 1=ERROR
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_addr  out  ADDR_WIDTH  captured HADDR
- rec_data  out  DATA_WIDTH  HWDATA for writes, HRDATA for reads
- rec_write, rec_seq, rec_err  out  1 each  HWRITE; HTRANS==SEQ; ERROR response
- rec_size, rec_burst  out  3 each;  rec_prot  out  4
- clr_stat  in  1  synchronous clear of ovf, drop_cnt, txn_cnt, proto_err
- level  out  LW  FIFO occupancy 0..DEPTH
- ovf  out  1  sticky: a record was dropped
- drop_cnt  out  16  saturating dropped-record count
- txn_cnt  out  32  wrapping count of records produced
- proto_err  out  1  sticky ERROR-response protocol violation

## Operation

- Address phase accepted at an edge where HREADY=1, HSEL=1, HTRANS[1]=1. HADDR, HWRITE, HSIZE, HBURST, HPROT and HTRANS[0] are latched into a pending slot.
- FSM: IDLE, DATA (pending slot, awaiting completion), ERR2 (first ERROR cycle seen).
  - IDLE -> DATA on acceptance.
  - DATA, HREADY=1: complete with rec_err=HRESP; next state DATA if a new address is accepted on the same edge, else IDLE.
  - DATA, HREADY=0, HRESP=1 -> ERR2. HREADY=0, HRESP=0: stay in DATA (wait state).
  - ERR2, HREADY=1, HRESP=1: complete with rec_err=1. Next state DATA/IDLE as above.
  - ERR2, any other combination: set proto_err; complete with rec_err=1; continue as above.
  - DATA, HREADY=1, HRESP=1 with no preceding ERR2 cycle: complete with rec_err=1 and set proto_err.
- Data selection at completion: HWDATA if the pending write bit is set, else HRDATA.
- Completion pushes one record and increments txn_cnt, wrapping at 2^32.
- FIFO behaviour:
  - Push when full with no pop on the same edge: drop the record, set ovf, increment drop_cnt (saturates at 0xFFFF).
  - Push and pop on the same edge when full: both succeed.
  - Pop on an edge where rec_valid && rec_ready.
- BUSY and IDLE transfers are never recorded. HSEL=0 with HTRANS active is ignored.
- clr_stat clears the statistics only. If a drop or protocol error occurs on the same edge, clr_stat wins. FIFO contents are untouched.

## Timing

- Reset (async assert, sync release): FSM=IDLE, FIFO empty, all outputs 0, including rec_* fields, level, ovf, drop_cnt, txn_cnt and proto_err.
- Latency: the record is visible (rec_valid=1) in the cycle after the completing edge. Minimum address-accept-to-rec_valid time is 2 cycles with zero wait states.
- rec_* fields are stable while rec_valid=1 && rec_ready=0.
- Back-to-back zero-wait transfers produce one record per cycle.
- level updates on the same edge as each push or pop.
- Reset asserted mid-transfer discards the pending slot and all FIFO contents. No record is produced for an interrupted transfer.

## Test plan

- Single write: NONSEQ, HADDR=0x100, HWRITE=1, HSIZE=2, HWDATA=0xDEADBEEF, no waits -> one record {0x100, 0xDEADBEEF, write=1, seq=0, err=0}, rec_valid 2 cycles after accept, txn_cnt=1.
- INCR4 read burst at 0x200 with zero waits and rec_ready=1 -> 4 consecutive records, addresses 0x200/0x204/0x208/0x20C, seq=0,1,1,1, data = HRDATA of each beat.
- Write to 0x40 with 3 wait states; HWDATA changes during the waits -> single record carrying HWDATA sampled on the HREADY=1 edge; level peaks at 1.
- ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> rec_err=1, proto_err=0. Single-cycle HRESP=1 with HREADY=1 -> rec_err=1, proto_err=1.
- DEPTH=8, rec_ready=0, 11 transfers -> level=8, ovf=1, drop_cnt=3, first 8 records intact. Then clr_stat -> ovf=0, drop_cnt=0, level still 8.
- HRESETn pulsed low in the DATA state with 3 records queued -> all outputs 0 immediately. After release, the next transfer yields txn_cnt=1.
